// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a single-ported RAM, registered outputs
module mem_arbiter #(
    parameter int WORD_W          = 32,
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              ihit,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dhit,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ramready
);

    localparam int SW = $clog2(DATA_STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [SW-1:0]     streak, streak_n;
    logic              ihit_n, dhit_n;
    logic              ren_n, wen_n;
    logic [WORD_W-1:0] addr_n, store_n, iload_n, dload_n;
    logic              i_elig, d_elig;

    // A port is not eligible in the cycle its hit is high: its requester
    // has not yet had a chance to drop or renew the request.
    assign i_elig = iREN && !ihit;
    assign d_elig = (dREN || dWEN) && !dhit;

    always_comb begin
        state_n  = state;
        streak_n = streak;
        ihit_n   = 1'b0;
        dhit_n   = 1'b0;
        ren_n    = ramREN;
        wen_n    = ramWEN;
        addr_n   = ramaddr;
        store_n  = ramstore;
        iload_n  = iload;
        dload_n  = dload;
        case (state)
            IDLE: begin
                if (d_elig && !(i_elig && streak == STREAK_MAX)) begin
                    state_n  = DACC;
                    ren_n    = !dWEN;
                    wen_n    = dWEN;
                    addr_n   = daddr;
                    store_n  = dstore;
                    if (!iREN)
                        streak_n = '0;
                    else if (streak != STREAK_MAX)
                        streak_n = streak + 1'b1;
                end else if (i_elig) begin
                    state_n  = IACC;
                    ren_n    = 1'b1;
                    wen_n    = 1'b0;
                    addr_n   = iaddr;
                    store_n  = dstore;
                    streak_n = '0;
                end
            end
            IACC: begin
                if (ramready) begin
                    state_n = IDLE;
                    ren_n   = 1'b0;
                    wen_n   = 1'b0;
                    ihit_n  = 1'b1;
                    iload_n = ramload;
                end
            end
            DACC: begin
                if (ramready) begin
                    state_n = IDLE;
                    ren_n   = 1'b0;
                    wen_n   = 1'b0;
                    dhit_n  = 1'b1;
                    if (ramREN)
                        dload_n = ramload;
                end
            end
            default: begin
                state_n = IDLE;
                ren_n   = 1'b0;
                wen_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            streak   <= '0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            iload    <= '0;
            dload    <= '0;
        end else begin
            state    <= state_n;
            streak   <= streak_n;
            ihit     <= ihit_n;
            dhit     <= dhit_n;
            ramREN   <= ren_n;
            ramWEN   <= wen_n;
            ramaddr  <= addr_n;
            ramstore <= store_n;
            iload    <= iload_n;
            dload    <= dload_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        ihit, dhit, ramREN, ramWEN, ramready;

    int vectors = 0;
    int miscompares = 0;

    // RAM responder: ready once the strobe has been up for wait_cycles cycles
    logic [3:0] cnt = '0;
    int         wait_cycles = 0;
    logic       rdy_auto_en = 1'b1;
    logic       rdy_force = 1'b0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cnt <= (ramREN | ramWEN) ? cnt + 4'd1 : 4'd0;

    assign ramready = rdy_force | (rdy_auto_en & (ramREN | ramWEN) & (int'(cnt) >= wait_cycles));

    mem_arbiter #(.WORD_W(32), .DATA_STREAK_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramready(ramready)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic seq [10];
        logic exp_seq [10];
        int   nhits;
        int   cyc;

        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        step();
        step();
        check("rst_ihit", {31'b0, ihit}, 32'd0);
        check("rst_dhit", {31'b0, dhit}, 32'd0);
        check("rst_ramREN", {31'b0, ramREN}, 32'd0);
        check("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        check("rst_iload", iload, 32'd0);
        check("rst_dload", dload, 32'd0);
        nRST = 1'b1;
        step();

        // single fetch, zero-wait RAM
        iREN = 1'b1; iaddr = 32'h0000_0040; ramload = 32'h2401_0005;
        step();
        check("t1_ramREN", {31'b0, ramREN}, 32'd1);
        check("t1_ramaddr", ramaddr, 32'h40);
        check("t1_ihit_early", {31'b0, ihit}, 32'd0);
        step();
        check("t1_ihit", {31'b0, ihit}, 32'd1);
        check("t1_iload", iload, 32'h2401_0005);
        check("t1_strobe_off", {31'b0, ramREN}, 32'd0);
        step();
        check("t1_no_regrant", {31'b0, ramREN}, 32'd0);
        check("t1_ihit_once", {31'b0, ihit}, 32'd0);
        iREN = 1'b0;
        step();

        // simultaneous fetch and data read: data wins, fetch granted in dhit cycle
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h80; ramload = 32'h1111_2222;
        step();
        check("t2_dgrant_ren", {31'b0, ramREN}, 32'd1);
        check("t2_dgrant_addr", ramaddr, 32'h80);
        step();
        check("t2_dhit", {31'b0, dhit}, 32'd1);
        check("t2_dload", dload, 32'h1111_2222);
        dREN = 1'b0; ramload = 32'h3333_4444;
        step();
        check("t2_igrant_ren", {31'b0, ramREN}, 32'd1);
        check("t2_igrant_addr", ramaddr, 32'h44);
        check("t2_dhit_once", {31'b0, dhit}, 32'd0);
        step();
        check("t2_ihit", {31'b0, ihit}, 32'd1);
        check("t2_iload", iload, 32'h3333_4444);
        iREN = 1'b0;
        step();

        // streak: data continuously pending, fetch present at every grant decision
        ramload = 32'h5555_AAAA; daddr = 32'h90; iaddr = 32'h48;
        dREN = 1'b1; iREN = 1'b1;
        nhits = 0; cyc = 0;
        while (nhits < 10 && cyc < 60) begin
            step();
            cyc++;
            if (dhit || ihit) begin
                seq[nhits] = ihit;
                nhits++;
            end
            check("t3_streak_bound", {31'b0, (dut.streak <= 3'd4)}, 32'd1);
            iREN = ~dhit;
        end
        check("t3_hit_count", nhits, 32'd10);
        for (int i = 0; i < 10; i++)
            check($sformatf("t3_seq%0d", i), {31'b0, seq[i]}, {31'b0, exp_seq[i]});
        iREN = 1'b0; dREN = 1'b0;
        step();
        step();
        step();

        // write with dREN too, one wait state, address changed mid-access
        wait_cycles = 1;
        ramload = 32'h9999_9999;
        dWEN = 1'b1; dREN = 1'b1; daddr = 32'hFC; dstore = 32'hDEAD_BEEF;
        step();
        check("t4_ramWEN", {31'b0, ramWEN}, 32'd1);
        check("t4_ramREN", {31'b0, ramREN}, 32'd0);
        check("t4_ramstore", ramstore, 32'hDEAD_BEEF);
        check("t4_ramaddr", ramaddr, 32'hFC);
        daddr = 32'h100; dstore = 32'h0; dWEN = 1'b0; dREN = 1'b0;
        step();
        check("t6_addr_held", ramaddr, 32'hFC);
        check("t6_wen_held", {31'b0, ramWEN}, 32'd1);
        check("t6_no_early_hit", {31'b0, dhit}, 32'd0);
        step();
        check("t4_dhit", {31'b0, dhit}, 32'd1);
        check("t4_dload_kept", dload, 32'h5555_AAAA);
        step();

        // reset during a long data access
        rdy_auto_en = 1'b0;
        dREN = 1'b1; daddr = 32'h20;
        step();
        check("t5_in_dacc", {31'b0, ramREN}, 32'd1);
        dREN = 1'b0;
        step();
        step();
        check("t5_still_wait", {31'b0, ramREN}, 32'd1);
        nRST = 1'b0;
        step();
        check("t5_ramREN", {31'b0, ramREN}, 32'd0);
        check("t5_ramWEN", {31'b0, ramWEN}, 32'd0);
        check("t5_dhit", {31'b0, dhit}, 32'd0);
        check("t5_ihit", {31'b0, ihit}, 32'd0);
        check("t5_streak", {29'b0, dut.streak}, 32'd0);
        check("t5_state", {30'b0, dut.state}, 32'd0);
        check("t5_dload", dload, 32'd0);
        nRST = 1'b1;
        rdy_force = 1'b1;
        step();
        check("t5_late_rdy_dhit", {31'b0, dhit}, 32'd0);
        step();
        check("t5_late_rdy_dhit2", {31'b0, dhit}, 32'd0);
        check("t5_late_rdy_ihit", {31'b0, ihit}, 32'd0);
        check("t5_late_rdy_ren", {31'b0, ramREN}, 32'd0);
        rdy_force = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
